aes_key_sched_ctrl: RTL and testbench

// - Sequences the key_gen datapath through the 10 AES-128 expansion rounds. Feeds back the previous round key and steps rcon.
// - Streams round keys 0..10 to the cipher core through a valid/ready handshake.
// - Sits between key-load logic and the round engine of the encrypt/decrypt top.

---
 rtl/aes_pkg.sv | 57 +++++
 rtl/aes_key_store.sv | 27 ++
 rtl/key_gen.sv | 31 +++
 rtl/aes_key_sched_ctrl.sv | 131 +++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: sizes, rcon seed, GF(2^8) helpers, S-box and the
// key-schedule FSM state type.
package aes_pkg;

    localparam int          AES_NK_BITS    = 128;
    localparam int          AES_NUM_ROUNDS = 10;
    localparam logic [31:0] RCON_INIT      = 32'h01000000;

    typedef logic [0:AES_NK_BITS-1] aes_key_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } ks_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; the zero byte maps to zero as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, sq);
            sq = gf_mul(sq, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_key_store.sv
// 11-entry round-key buffer with one write port and one asynchronous read port;
// only built when KEY_STORE_EN is defined.
`ifdef KEY_STORE_EN
module aes_key_store
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         i_we,
    input  logic [3:0]   i_wr_idx,
    input  logic [0:127] i_wr_key,
    input  logic [3:0]   i_rd_idx,
    output logic [0:127] o_rd_key
);

    aes_key_t r_mem [0:AES_NUM_ROUNDS];

    // NOTE: the storage array has no reset; store_full in the controller qualifies its contents.
    always_ff @(posedge clk) begin
        if (i_we && (i_wr_idx <= 4'(AES_NUM_ROUNDS))) begin
            r_mem[i_wr_idx] <= i_wr_key;
        end
    end

    assign o_rd_key = (i_rd_idx <= 4'(AES_NUM_ROUNDS)) ? r_mem[i_rd_idx] : '0;

endmodule
`endif

// File: rtl/key_gen.sv
// One AES-128 key-expansion round: derives the next round key from the previous
// one and the current rcon word. Purely combinational.
module key_gen
    import aes_pkg::*;
(
    input  logic [0:127] temp_key,
    input  logic [0:31]  rcon,
    input  logic [0:127] mx_key,
    output logic [0:127] ko
);

    logic [0:31] w_w0, w_w1, w_w2, w_w3;
    logic [0:31] w_t;
    logic [0:31] w_n0, w_n1, w_n2, w_n3;

    // NOTE: every signal written here is assigned on every path, so no latch is inferred.
    always_comb begin
        w_w0 = temp_key[0:31];
        w_w1 = temp_key[32:63];
        w_w2 = temp_key[64:95];
        w_w3 = temp_key[96:127];
        w_t  = sub_word({w_w3[8:31], w_w3[0:7]}) ^ rcon;
        w_n0 = w_w0 ^ w_t;
        w_n1 = w_w1 ^ w_n0;
        w_n2 = w_w2 ^ w_n1;
        w_n3 = w_w3 ^ w_n2;
        // mx_key lets a caller fold an extra mask into the result; zero leaves the key untouched.
        ko   = {w_n0, w_n1, w_n2, w_n3} ^ mx_key;
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller: streams round keys 0..10 over valid/ready.
// Define KEY_STORE_EN to add the 11-entry key store and its read port.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [0:127] key_in,
    output logic         ready,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [0:127] rk_out,
    output logic [3:0]   rk_idx,
    output logic         done
`ifdef KEY_STORE_EN
    ,
    input  logic [3:0]   rd_idx,
    output logic [0:127] rd_key,
    output logic         store_full
`endif
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    ks_state_t   r_state;
    ks_state_t   w_next_state;
    aes_key_t    r_key;
    logic [3:0]  r_idx;
    logic [0:31] r_rcon;
    aes_key_t    w_ko;
    logic        w_accept;
    logic        w_hs;
    logic        w_abort;

    assign w_accept = (r_state == IDLE) && start && !abort;
    assign w_hs     = (r_state == EMIT) && rk_ready && !abort;
    assign w_abort  = (r_state != IDLE) && abort;

    key_gen u_key_gen (
        .temp_key (r_key),
        .rcon     (r_rcon),
        .mx_key   ('0),
        .ko       (w_ko)
    );

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        ready        = 1'b0;
        rk_valid     = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start && !abort) w_next_state = EMIT;
            end
            EMIT: begin
                rk_valid = 1'b1;
                if (abort) begin
                    w_next_state = IDLE;
                end else if (rk_ready && (r_idx == LAST_IDX)) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done         = !abort;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // The final handshake leaves key and index in place so rk_out still shows key 10.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key  <= '0;
            r_idx  <= '0;
            r_rcon <= RCON_INIT;
        end else if (w_accept) begin
            r_key  <= key_in;
            r_idx  <= '0;
            r_rcon <= RCON_INIT;
        end else if (w_hs && (r_idx != LAST_IDX)) begin
            r_key  <= w_ko;
            r_idx  <= r_idx + 4'd1;
            r_rcon <= {xtime(r_rcon[0:7]), 24'h000000};
        end
    end

    assign rk_out = r_key;
    assign rk_idx = r_idx;

`ifdef KEY_STORE_EN
    logic r_store_full;

    aes_key_store u_key_store (
        .clk      (clk),
        .i_we     (w_hs),
        .i_wr_idx (r_idx),
        .i_wr_key (r_key),
        .i_rd_idx (rd_idx),
        .o_rd_key (rd_key)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_store_full <= 1'b0;
        end else if (w_accept || w_abort) begin
            r_store_full <= 1'b0;
        end else if (w_hs && (r_idx == LAST_IDX)) begin
            r_store_full <= 1'b1;
        end
    end

    assign store_full = r_store_full;
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed testbench for aes_key_sched_ctrl using FIPS-197 key-expansion vectors.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_aes_key_sched_ctrl;

    logic         clk;
    logic         rst;
    logic         start;
    logic         abort;
    logic [127:0] key_in;
    logic         ready;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         done;
`ifdef KEY_STORE_EN
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    logic         store_full;
`endif

    int total;
    int bad;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [127:0] fips_rk [0:10];

    aes_key_sched_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .key_in   (key_in),
        .ready    (ready),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .done     (done)
`ifdef KEY_STORE_EN
        ,
        .rd_idx     (rd_idx),
        .rd_key     (rd_key),
        .store_full (store_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_run(input logic [127:0] k);
        @(negedge clk);
        key_in = k;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_idx(input logic [3:0] target, input string tag);
        int c;
        c = 0;
        while (!(rk_valid === 1'b1 && rk_idx === target) && c < 50) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (c >= 50) begin
            bad++;
            $display("FAIL %s_timeout: rk_idx=%0d never reached %0d", tag, rk_idx, target);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (ready !== 1'b1 || rk_valid !== 1'b0 || rk_out !== 128'h0 || rk_idx !== 4'd0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b valid=%b out=%h idx=%0d done=%b", ready, rk_valid, rk_out, rk_idx, done);
        end
        total++;
        if (dut.r_rcon !== 32'h01000000) begin
            bad++;
            $display("FAIL reset_rcon: got %h want 01000000", dut.r_rcon);
        end
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        int pulses;
        rk_ready = 1'b1;
        start_run(FIPS_KEY);
        for (int i = 0; i <= 10; i++) begin
            total++;
            if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk_out !== fips_rk[i]) begin
                bad++;
                $display("FAIL free_key%0d: valid=%b idx=%0d out=%h want %h", i, rk_valid, rk_idx, rk_out, fips_rk[i]);
            end
            if (i == 8) begin
                total++;
                if (dut.r_rcon[0:7] !== 8'h1b) begin
                    bad++;
                    $display("FAIL rcon_8to9: got %h want 1b", dut.r_rcon[0:7]);
                end
            end
            if (i == 9) begin
                total++;
                if (dut.r_rcon[0:7] !== 8'h36) begin
                    bad++;
                    $display("FAIL rcon_9to10: got %h want 36", dut.r_rcon[0:7]);
                end
            end
            @(negedge clk);
        end
        total++;
        if (rk_valid !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL free_done_state: valid=%b done=%b want 0/1", rk_valid, done);
        end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        total++;
        if (pulses != 1 || ready !== 1'b1) begin
            bad++;
            $display("FAIL free_done_pulse: pulses=%0d ready=%b want 1/1", pulses, ready);
        end
    endtask

    task automatic test_backpressure();
        int         accepted;
        bit         stalled;
        bit         finished;
        logic [127:0] prev_out;
        logic [3:0] prev_idx;
        accepted = 0;
        stalled  = 1'b0;
        finished = 1'b0;
        prev_out = '0;
        prev_idx = '0;
        rk_ready = 1'b0;
        start_run(FIPS_KEY);
        for (int c = 0; c < 400 && !finished; c++) begin
            if (rk_valid === 1'b1) begin
                total++;
                if (rk_idx !== 4'(accepted) || rk_out !== fips_rk[accepted]) begin
                    bad++;
                    $display("FAIL bp_key%0d: idx=%0d out=%h want %h", accepted, rk_idx, rk_out, fips_rk[accepted]);
                end
                if (stalled) begin
                    total++;
                    if (rk_out !== prev_out || rk_idx !== prev_idx) begin
                        bad++;
                        $display("FAIL bp_stable: idx=%0d out=%h want idx=%0d out=%h", rk_idx, rk_out, prev_idx, prev_out);
                    end
                end
            end
            rk_ready = 1'($urandom_range(0, 1));
            stalled  = (rk_valid === 1'b1) && !rk_ready;
            prev_out = rk_out;
            prev_idx = rk_idx;
            if (rk_valid === 1'b1 && rk_ready) begin
                if (rk_idx === 4'd10) finished = 1'b1;
                accepted++;
            end
            @(negedge clk);
        end
        total++;
        if (!finished || done !== 1'b1) begin
            bad++;
            $display("FAIL bp_complete: finished=%0d accepted=%0d done=%b", finished, accepted, done);
        end
        rk_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abort();
        int pulses;
        rk_ready = 1'b1;
        start_run(FIPS_KEY);
        wait_idx(4'd4, "abort_wait");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if (rk_valid !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: valid=%b ready=%b done=%b want 0/1/0", rk_valid, ready, done);
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL abort_no_done: pulses=%0d want 0", pulses);
        end
        start_run(128'h0);
        total++;
        if (rk_idx !== 4'd0 || rk_out !== 128'h0) begin
            bad++;
            $display("FAIL zero_key0: idx=%0d out=%h want 0", rk_idx, rk_out);
        end
        @(negedge clk);
        total++;
        if (rk_idx !== 4'd1 || rk_out !== 128'h62636363626363636263636362636363) begin
            bad++;
            $display("FAIL zero_key1: idx=%0d out=%h want 6263...6363", rk_idx, rk_out);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_start_in_emit();
        rk_ready = 1'b1;
        @(negedge clk);
        key_in = FIPS_KEY;
        start  = 1'b1;
        @(negedge clk);
        for (int i = 0; i <= 10; i++) begin
            total++;
            if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk_out !== fips_rk[i]) begin
                bad++;
                $display("FAIL hold_start_key%0d: idx=%0d out=%h want %h", i, rk_idx, rk_out, fips_rk[i]);
            end
            if (i == 10) start = 1'b0;
            @(negedge clk);
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL hold_start_done: done=%b want 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_start_abort_idle();
        start  = 1'b1;
        abort  = 1'b1;
        key_in = FIPS_KEY;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (ready !== 1'b1 || rk_valid !== 1'b0) begin
                bad++;
                $display("FAIL start_abort_idle%0d: ready=%b valid=%b want 1/0", i, ready, rk_valid);
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        rk_ready = 1'b1;
        start_run(FIPS_KEY);
        wait_idx(4'd6, "rst_wait");
        #2 rst = 1'b1;
        #1;
        total++;
        if (ready !== 1'b1 || rk_valid !== 1'b0 || rk_out !== 128'h0 || rk_idx !== 4'd0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: ready=%b valid=%b out=%h idx=%0d done=%b", ready, rk_valid, rk_out, rk_idx, done);
        end
        total++;
        if (dut.r_rcon !== 32'h01000000) begin
            bad++;
            $display("FAIL reset_mid_rcon: got %h want 01000000", dut.r_rcon);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef KEY_STORE_EN
    task automatic test_key_store();
        rk_ready = 1'b1;
        start_run(FIPS_KEY);
        wait_idx(4'd10, "store_wait");
        @(negedge clk);
        @(negedge clk);
        rd_idx = 4'd10;
        #1;
        total++;
        if (rd_key !== fips_rk[10] || store_full !== 1'b1) begin
            bad++;
            $display("FAIL store_rd10: key=%h full=%b want %h/1", rd_key, store_full, fips_rk[10]);
        end
        rd_idx = 4'd11;
        #1;
        total++;
        if (rd_key !== 128'h0) begin
            bad++;
            $display("FAIL store_rd11: key=%h want 0", rd_key);
        end
        rd_idx = 4'd0;
        #1;
        total++;
        if (rd_key !== fips_rk[0]) begin
            bad++;
            $display("FAIL store_rd0: key=%h want %h", rd_key, fips_rk[0]);
        end
        start_run(FIPS_KEY);
        total++;
        if (store_full !== 1'b0) begin
            bad++;
            $display("FAIL store_clear: full=%b want 0", store_full);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask
`endif

    initial begin
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        rk_ready = 1'b0;
        key_in   = '0;
`ifdef KEY_STORE_EN
        rd_idx   = '0;
`endif
        test_reset();
        test_free_run();
        test_backpressure();
        test_abort();
        test_start_in_emit();
        test_start_abort_idle();
        test_reset_mid();
`ifdef KEY_STORE_EN
        test_key_store();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
